// File: rtl/gaus_pkg.sv
// Shared types and constants for the Gaussian lane scheduler.
// Holds the FSM encoding, LFSR width and default seed stride.
package gaus_pkg;

    localparam int LFSR_W = 23;
    localparam logic [LFSR_W-1:0] SEED_NONZERO = 23'h000001;
    localparam logic [LFSR_W-1:0] SEED_STRIDE_DFLT = 23'd1048583;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_WARM = 2'd2,
        ST_RUN  = 2'd3
    } gaus_sched_state_t;

    // An all-zero LFSR state never leaves zero, so it is replaced.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? SEED_NONZERO : s;
    endfunction

endpackage

// File: rtl/gaus_popcnt.sv
// Combinational population count of an N-bit lane vector.
// Shared between the scheduler and the generator datapath.
module gaus_popcnt #(
    parameter int N = 8
) (
    input  logic [N-1:0]               i_bits,
    output logic [$clog2(N+1)-1:0]     o_cnt
);

    localparam int CW = $clog2(N + 1);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < N; i++) begin
            o_cnt = o_cnt + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/gaus_sched.sv
// Seeds an LFSR bank, warms it up, then emits CLT Gaussian samples.
// Optional drop counter: define GAUS_SCHED_DROP_CNT_EN.
module gaus_sched
    import gaus_pkg::*;
#(
    parameter int                N_LANES     = 8,
    parameter int                N_TRIALS    = 8,
    parameter int                WARMUP      = 32,
    parameter int                OUT_W       = 12,
    parameter logic [OUT_W-1:0]  OFFSET      = 'h100,
    parameter logic [LFSR_W-1:0] SEED_STRIDE = SEED_STRIDE_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reseed_req,
    input  logic [LFSR_W-1:0]    reseed_seed,
    output logic                 reseed_ack,
    output logic                 busy,
    output logic [LFSR_W-1:0]    lane_seed,
    output logic [N_LANES-1:0]   lane_seed_wr,
    input  logic [N_LANES-1:0]   lane_y,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_data,
    input  logic                 out_ready,
    output logic [15:0]          drop_cnt
);

    localparam int CNT_W  = $clog2(N_LANES + 1);
    localparam int ACC_W  = $clog2(N_LANES * N_TRIALS + 1);
    localparam int SH     = $clog2(N_TRIALS);
    localparam int LANE_W = $clog2(N_LANES);
    localparam int WARM_W = $clog2(WARMUP + 1);

    gaus_sched_state_t r_state;
    logic [LFSR_W-1:0] r_seed;
    logic [LANE_W-1:0] r_lane;
    logic [WARM_W-1:0] r_warm;
    logic [SH-1:0]     r_win;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ack;
    logic              r_valid;
    logic [OUT_W-1:0]  r_data;

    logic [CNT_W-1:0]  w_cnt;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W:0]    w_round;
    logic [ACC_W:0]    w_scaled;
    logic [OUT_W-1:0]  w_sample;
    logic              w_seed_st;
    logic              w_win_end;
    logic              w_accept;
    logic              w_load;

    gaus_popcnt #(
        .N (N_LANES)
    ) u_popcnt (
        .i_bits (lane_y),
        .o_cnt  (w_cnt)
    );

    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(w_cnt);
    assign w_round   = w_sum + (ACC_W+1)'(N_TRIALS / 2);
    assign w_scaled  = w_round >> SH;
    assign w_sample  = OUT_W'(w_scaled) + OFFSET;
    assign w_seed_st = (r_state == ST_SEED);
    assign w_win_end = (r_state == ST_RUN) && (&r_win);
    assign w_accept  = r_valid & out_ready;
    assign w_load    = w_win_end & (~r_valid | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_seed  <= '0;
            r_lane  <= '0;
            r_warm  <= '0;
            r_win   <= '0;
            r_acc   <= '0;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_ack <= reseed_req;
            if (reseed_req) begin
                r_state <= ST_SEED;
                r_seed  <= reseed_seed;
                r_lane  <= '0;
                r_warm  <= '0;
                r_win   <= '0;
                r_acc   <= '0;
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                    end
                    ST_SEED: begin
                        r_seed <= r_seed + SEED_STRIDE;
                        r_lane <= r_lane + 1'b1;
                        if (r_lane == LANE_W'(N_LANES - 1)) begin
                            r_state <= ST_WARM;
                            r_warm  <= '0;
                        end
                    end
                    ST_WARM: begin
                        r_warm <= r_warm + 1'b1;
                        if (r_warm == WARM_W'(WARMUP - 1)) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        r_win <= r_win + 1'b1;
                        r_acc <= w_win_end ? '0 : w_sum[ACC_W-1:0];
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
                if (w_load) begin
                    r_valid <= 1'b1;
                    r_data  <= w_sample;
                end else if (w_accept) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

`ifdef GAUS_SCHED_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop;

    assign w_drop = w_win_end & r_valid & ~out_ready & ~reseed_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    assign drop_cnt = r_drop;
`else
    assign drop_cnt = '0;
`endif

    assign reseed_ack   = r_ack;
    assign busy         = w_seed_st || (r_state == ST_WARM);
    assign lane_seed    = w_seed_st ? seed_fix(r_seed) : '0;
    assign lane_seed_wr = w_seed_st ?
                          ({{(N_LANES-1){1'b0}}, 1'b1} << r_lane) : '0;
    assign out_valid    = r_valid;
    assign out_data     = r_data;

endmodule

// File: tb/tb_gaus_sched.sv
// Directed bench for gaus_sched with a cycle-offset reference model.
// Honours GAUS_SCHED_DROP_CNT_EN for the expected drop count.
module tb_gaus_sched;

`ifdef GAUS_SCHED_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    localparam int STRIDE = 1048583;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reseed_req = 1'b0;
    logic [22:0] reseed_seed = '0;
    logic        reseed_ack;
    logic        busy;
    logic [22:0] lane_seed;
    logic [7:0]  lane_seed_wr;
    logic [7:0]  lane_y = '0;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_ready = 1'b0;
    logic [15:0] drop_cnt;

    int checks = 0;
    int failures = 0;
    int rel = 0;

    gaus_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reseed_req   (reseed_req),
        .reseed_seed  (reseed_seed),
        .reseed_ack   (reseed_ack),
        .busy         (busy),
        .lane_seed    (lane_seed),
        .lane_seed_wr (lane_seed_wr),
        .lane_y       (lane_y),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [22:0] exp_seed(input logic [22:0] b, input int k);
        logic [63:0] t;
        t = 64'(b) + 64'(k) * 64'(STRIDE);
        return (t[22:0] == 23'd0) ? 23'd1 : t[22:0];
    endfunction

    // Reference model: position since ack decides phase, window sums by arithmetic.
    bit          m_on = 1'b0;
    bit          m_ack = 1'b0;
    bit          m_vld = 1'b0;
    int          m_d = 0;
    logic [22:0] m_base = '0;
    int          m_sum = 0;
    logic [11:0] m_data = '0;
    int          m_drop = 0;
    bit          m_take;
    bit          m_wend;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_on = 1'b0; m_ack = 1'b0; m_vld = 1'b0;
            m_sum = 0; m_drop = 0; m_d = 0;
        end
        chk("ack", 32'(reseed_ack), 32'(m_ack));
        chk("busy", 32'(busy), 32'(m_on && m_d < 40));
        chk("wr", 32'(lane_seed_wr),
            (m_on && m_d < 8) ? (32'd1 << m_d) : 32'd0);
        chk("seed", 32'(lane_seed),
            (m_on && m_d < 8) ? 32'(exp_seed(m_base, m_d)) : 32'd0);
        chk("valid", 32'(out_valid), 32'(m_vld));
        if (m_vld) chk("data", 32'(out_data), 32'(m_data));
        chk("drop", 32'(drop_cnt), DROP_EN ? 32'(m_drop) : 32'd0);
        if (rst_n) begin
            m_take = m_vld && out_ready;
            m_wend = 1'b0;
            if (reseed_req) begin
                m_ack = 1'b1; m_on = 1'b1; m_d = 0;
                m_base = reseed_seed; m_sum = 0; m_vld = 1'b0;
            end else begin
                m_ack = 1'b0;
                if (m_on && m_d >= 40) begin
                    m_sum += $countones(lane_y);
                    if ((m_d - 40) % 8 == 7) begin
                        m_wend = 1'b1;
                        if (!m_vld || out_ready) begin
                            m_vld = 1'b1;
                            m_data = 12'(((m_sum + 4) >> 3) + 256);
                        end else if (m_drop < 65535) begin
                            m_drop++;
                        end
                        m_sum = 0;
                    end
                end
                if (!m_wend && m_take) m_vld = 1'b0;
                if (m_on) m_d++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic to(input int n);
        while (rel < n) step();
    endtask

    task automatic at(input int n);
        to(n);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr", 32'(lane_seed_wr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) step();

        reseed_seed = 23'd0; reseed_req = 1'b1;
        lane_y = 8'hFF; out_ready = 1'b1; rel = 0;
        step(); reseed_req = 1'b0;
        @(negedge clk);
        chk("lit_ack1", 32'(reseed_ack), 32'd1);
        chk("lit_wr1", 32'(lane_seed_wr), 32'h01);
        chk("lit_seed1", 32'(lane_seed), 32'd1);
        at(2);
        chk("lit_seed2", 32'(lane_seed), 32'd1048583);
        chk("lit_wr2", 32'(lane_seed_wr), 32'h02);
        at(40); chk("lit_busy40", 32'(busy), 32'd1);
        at(41); chk("lit_busy41", 32'(busy), 32'd0);
        at(48); chk("lit_val48", 32'(out_valid), 32'd0);
        at(49);
        chk("lit_val49", 32'(out_valid), 32'd1);
        chk("lit_ff", 32'(out_data), 32'h108);
        to(57); lane_y = 8'h00;
        to(65); lane_y = 8'h0F;
        @(negedge clk);
        chk("lit_00", 32'(out_data), 32'h100);
        to(73); lane_y = 8'hFF; out_ready = 1'b0;
        @(negedge clk);
        chk("lit_0f", 32'(out_data), 32'h104);
        at(97);
        chk("lit_hold", 32'(out_data), 32'h104);
        chk("lit_drop3", 32'(drop_cnt), DROP_EN ? 32'd3 : 32'd0);
        to(104); out_ready = 1'b1;
        to(105); out_ready = 1'b0;
        @(negedge clk);
        chk("lit_pulse", 32'(out_data), 32'h108);
        chk("lit_drop_same", 32'(drop_cnt), DROP_EN ? 32'd3 : 32'd0);

        to(106);
        reseed_seed = 23'd5242859; reseed_req = 1'b1;
        lane_y = 8'h0F; rel = 0;
        step(); reseed_req = 1'b0;
        @(negedge clk);
        chk("lit_rs_val", 32'(out_valid), 32'd0);
        chk("lit_rs_wr", 32'(lane_seed_wr), 32'h01);
        chk("lit_rs_seed", 32'(lane_seed), 32'd5242859);
        at(4);
        chk("lit_wrap_seed", 32'(lane_seed), 32'd1);
        at(48); chk("lit_rs_val48", 32'(out_valid), 32'd0);
        to(49); out_ready = 1'b1;
        @(negedge clk);
        chk("lit_rs_val49", 32'(out_valid), 32'd1);
        chk("lit_rs_data", 32'(out_data), 32'h104);

        to(55);
        reseed_seed = 23'h123; reseed_req = 1'b1; rel = 0;
        step(); reseed_req = 1'b0;
        at(4);
        chk("lit_lane3", 32'(lane_seed_wr), 32'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_arst_wr", 32'(lane_seed_wr), 32'd0);
        chk("lit_arst_seed", 32'(lane_seed), 32'd0);
        chk("lit_arst_busy", 32'(busy), 32'd0);
        chk("lit_arst_drop", 32'(drop_cnt), 32'd0);
        to(7); rst_n = 1'b1;
        at(20);
        chk("lit_idle_wr", 32'(lane_seed_wr), 32'd0);
        chk("lit_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gaus_sched.md
# gaus_sched

Controller and scheduler for a bank of `lfsr_23_4_22` lanes that feed a central-limit-theorem Gaussian generator.
- Seeds every lane from one host-supplied base seed, one lane per cycle, then lets the bank warm up.
- Runs fixed-length accumulation windows over the lane bits and emits one 12-bit Gaussian sample per window on a valid/ready stream.
- Sits between host configuration logic and the LFSR bank; replaces free-running, power-up-seeded operation.

## Interface
Parameters:
- `N_LANES`, 8, number of LFSR lanes (2..16).
- `N_TRIALS`, 8, cycles per accumulation window; power of 2, ≥2.
- `WARMUP`, 32, cycles between last seed write and first accumulation (≥1).
- `OUT_W`, 12, sample width.
- `OFFSET`, 12'h100, added to each scaled sum.
- `SEED_STRIDE`, 23'd1048583, per-lane seed increment.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `reseed_req`  in  1  level request to (re)seed using `reseed_seed`.
- `reseed_seed`  in  23  base seed, sampled with `reseed_req`.
- `reseed_ack`  out  1  one-cycle pulse: request accepted.
- `busy`  out  1  high in SEED and WARM.
- `lane_seed`  out  23  seed value for the lane currently written.
- `lane_seed_wr`  out  N_LANES  one-hot write strobe to lane k's `seed_wr`.
- `lane_y`  in  N_LANES  lane output bits.
- `out_valid`  out  1  sample available.
- `out_data`  out  OUT_W  sample.
- `out_ready`  in  1  consumer accepts the sample.
- `drop_cnt`  out  16  saturating count of samples dropped by backpressure.

## Operation
- Reset values: all outputs 0. FSM in IDLE; accumulator, counters and sample register cleared.
- FSM states: IDLE, SEED, WARM, RUN.
- IDLE → SEED when `reseed_req`=1.
- Any state → SEED on `reseed_req`=1, which restarts the sequence:
  - accumulator and window counter cleared;
  - any held sample discarded, `out_valid`←0;
  - `drop_cnt` not cleared.
- Seed derivation: seed_k = (base + k·SEED_STRIDE) mod 2^23, computed with an incremental adder. If seed_k is 0, drive 23'h000001 instead; an all-zero state would lock up the LFSR.
- SEED → WARM after N_LANES cycles. WARM → RUN after WARMUP cycles. RUN persists until reseed or reset.
- RUN accumulation: each cycle add popcount(`lane_y`) (0..N_LANES) to the window accumulator. The accumulator is ⌈log2(N_LANES·N_TRIALS+1)⌉ bits wide and cannot overflow.
- Window end: sample = ((acc + N_TRIALS/2) >> log2(N_TRIALS)) + OFFSET, truncated to OUT_W. The accumulator restarts from the next cycle's popcount, with no gap cycle.
- Output slot is one entry:
  - Slot empty, or being accepted (`out_valid`&`out_ready`) on the same cycle → new sample loads. No drop.
  - Otherwise → new sample discarded, held sample unchanged, `drop_cnt`+1, saturating at 16'hFFFF.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Timing
- `reseed_req` sampled high at cycle t:
  - t+1: `reseed_ack`=1, state SEED, `lane_seed_wr`[0]=1.
  - t+1+k: `lane_seed_wr`[k]=1, `lane_seed`=seed_k.
- WARM covers t+1+N_LANES .. t+N_LANES+WARMUP. RUN begins at t+1+N_LANES+WARMUP.
- First `out_valid` is N_TRIALS cycles after RUN begins. Subsequent windows complete every N_TRIALS cycles.
- `reseed_req` held high re-triggers every cycle. Hosts deassert it on `reseed_ack`.
- Reset asserted mid-sequence returns everything to reset values immediately; no partial seed strobes follow.

## Configuration
- `GAUS_SCHED_DROP_CNT_EN` defined: `drop_cnt` counter implemented as described.
- Undefined: `drop_cnt` tied to 0, no counter logic. Drop behaviour itself is unchanged.

## Structure
- Shared package `gaus_pkg` holds:
  - FSM state enum `gaus_sched_state_t` (IDLE, SEED, WARM, RUN);
  - `LFSR_W` = 23 and `SEED_NONZERO` = 23'h000001;
  - the default `SEED_STRIDE`.
- One sub-module, `gaus_popcnt`: combinational popcount of N_LANES bits, reusable by the generator datapath.

## Test plan
- Reseed with base 0, default params, req at cycle 0:
  - ack at 1; `lane_seed`=1 with `lane_seed_wr`=8'h01 at 1 (zero substitution);
  - `lane_seed`=1048583 at 2;
  - `busy` high cycles 1–40; first `out_valid` at 49.
- RUN with `lane_y`=8'hFF constant, `out_ready`=1 → every sample 12'h108. With `lane_y`=8'h00 → 12'h100. With `lane_y`=8'h0F → 12'h104.
- `out_ready`=0 for 3 windows after first valid → `out_data` held at the first sample, `drop_cnt`=3 (with `GAUS_SCHED_DROP_CNT_EN`), 0 without.
- `out_ready` pulses exactly on a window-end cycle → new sample loads, `drop_cnt` unchanged.
- `reseed_req` mid-RUN with a sample pending → `out_valid`=0 next cycle, strobes restart at lane 0, first new sample 48 cycles after ack.
- `rst_n` low during SEED at lane 3 → all outputs 0 immediately, no further `lane_seed_wr`, IDLE until next request.
